// File: rtl/translater_bank.sv
`default_nettype none
// ============================================================================
//  Module   : translater_bank
//  Brief    : NUM_CH-channel load/hold register bank with per-channel valid,
//             saturating hold-age counter, stale flag and load strobe.
//             Optional macro TRANSLATER_PARITY_EN adds out_parity.
//  Revision : 1.0  initial release
// ============================================================================
module translater_bank #(
   parameter int NUM_CH   = 4,
   parameter int WIDTH    = 8,
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
   input  logic                    clk,
   input  logic                    reset_L,
   input  logic                    ENB,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH-1:0]       selector,
   output logic [NUM_CH*WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]       out_valid,
   output logic [NUM_CH-1:0]       load_pulse,
`ifdef TRANSLATER_PARITY_EN
   output logic [NUM_CH-1:0]       out_parity,
`endif
   output logic [NUM_CH-1:0]       stale
);

   localparam logic [CNT_W-1:0] C_HOLD_MAX = CNT_W'(HOLD_MAX);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] data_q, data_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             valid_q, valid_d;
      logic             pulse_q, pulse_d;
      logic             stale_q, stale_d;

      // stale is precomputed from next-state values so it leaves a flop
      // in the same cycle its inputs do.
      always_comb begin
         data_d  = data_q;
         valid_d = valid_q;
         cnt_d   = cnt_q;
         pulse_d = 1'b0;
         if (ENB) begin
            if (!selector[gi]) begin
               data_d  = in_data[gi*WIDTH +: WIDTH];
               valid_d = in_valid[gi];
               cnt_d   = '0;
               pulse_d = in_valid[gi];
            end else if (cnt_q != C_HOLD_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         stale_d = valid_d && (cnt_d == C_HOLD_MAX);
      end

      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            stale_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            stale_q <= stale_d;
         end
      end

      assign out_data[gi*WIDTH +: WIDTH] = data_q;
      assign out_valid[gi]               = valid_q;
      assign load_pulse[gi]              = pulse_q;
      assign stale[gi]                   = stale_q;

`ifdef TRANSLATER_PARITY_EN
      logic par_q, par_d;

      always_comb begin
         par_d = par_q;
         if (ENB && !selector[gi]) begin
            par_d = ^in_data[gi*WIDTH +: WIDTH];
         end
      end

      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            par_q <= 1'b0;
         end else begin
            par_q <= par_d;
         end
      end

      assign out_parity[gi] = par_q;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_translater_bank.sv
`default_nettype none
// Testbench for translater_bank (NUM_CH=4, WIDTH=8, HOLD_MAX=3) with a
// queue-based scoreboard fed by a behavioural reference model.
module tb_translater_bank;

   localparam int NUM_CH   = 4;
   localparam int WIDTH    = 8;
   localparam int HOLD_MAX = 3;

   logic        clk;
   logic        reset_L;
   logic        enb;
   logic [31:0] idata;
   logic [3:0]  ivld;
   logic [3:0]  sel;
   logic [31:0] out_data;
   logic [3:0]  out_valid;
   logic [3:0]  load_pulse;
   logic [3:0]  stale;
   logic [3:0]  out_parity;

   translater_bank #(
      .NUM_CH  (NUM_CH),
      .WIDTH   (WIDTH),
      .HOLD_MAX(HOLD_MAX)
   ) dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .ENB       (enb),
      .in_data   (idata),
      .in_valid  (ivld),
      .selector  (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .load_pulse(load_pulse),
`ifdef TRANSLATER_PARITY_EN
      .out_parity(out_parity),
`endif
      .stale     (stale)
   );

`ifndef TRANSLATER_PARITY_EN
   assign out_parity = 4'b0000;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  valid;
      logic [3:0]  pulse;
      logic [3:0]  stale;
      logic [3:0]  parity;
   } exp_t;

   exp_t exp_q[$];

   logic [7:0] m_data[4];
   logic       m_valid[4];
   logic       m_pulse[4];
   logic       m_par[4];
   int         m_cnt[4];

   int vectors    = 0;
   int miscompares = 0;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_data[i]  = 8'h00;
         m_valid[i] = 1'b0;
         m_pulse[i] = 1'b0;
         m_par[i]   = 1'b0;
         m_cnt[i]   = 0;
      end
   endtask

   function automatic exp_t model_snapshot();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.data[i*8 +: 8] = m_data[i];
         e.valid[i]       = m_valid[i];
         e.pulse[i]       = m_pulse[i];
         e.stale[i]       = m_valid[i] && (m_cnt[i] == HOLD_MAX);
`ifdef TRANSLATER_PARITY_EN
         e.parity[i]      = m_par[i];
`else
         e.parity[i]      = 1'b0;
`endif
      end
      return e;
   endfunction

   // Advance the model by one edge using the currently driven inputs.
   task automatic model_edge();
      for (int i = 0; i < 4; i++) begin
         if (!enb) begin
            m_pulse[i] = 1'b0;
         end else if (sel[i] == 1'b0) begin
            m_data[i]  = idata[i*8 +: 8];
            m_valid[i] = ivld[i];
            m_pulse[i] = ivld[i];
            m_par[i]   = ^idata[i*8 +: 8];
            m_cnt[i]   = 0;
         end else begin
            m_pulse[i] = 1'b0;
            if (m_cnt[i] < HOLD_MAX) m_cnt[i] = m_cnt[i] + 1;
         end
      end
   endtask

   task automatic step();
      exp_t e;
      exp_t got;
      model_edge();
      exp_q.push_back(model_snapshot());
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      got = {out_data, out_valid, load_pulse, stale, out_parity};
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL scoreboard t=%0t: got data=%h vld=%b pls=%b stl=%b par=%b, want data=%h vld=%b pls=%b stl=%b par=%b",
                  $time, got.data, got.valid, got.pulse, got.stale, got.parity,
                  e.data, e.valid, e.pulse, e.stale, e.parity);
      end
   endtask

   task automatic test_reset();
      reset_L = 1'b0;
      for (int k = 0; k < 3; k++) begin
         enb   = 1'b1;
         sel   = 4'($urandom);
         ivld  = 4'($urandom);
         idata = $urandom;
         @(posedge clk);
         #1;
         vectors++;
         if ({out_data, out_valid, load_pulse, stale, out_parity} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_hold: got data=%h vld=%b pls=%b stl=%b, want all zero",
                     out_data, out_valid, load_pulse, stale);
         end
      end
      reset_L = 1'b1;
      model_reset();
      enb   = 1'b1;
      sel   = 4'b0000;
      ivld  = 4'b1111;
      idata = 32'h44332211;
      step();
      vectors++;
      if (out_data !== 32'h44332211 || out_valid !== 4'b1111 || load_pulse !== 4'b1111) begin
         miscompares++;
         $display("FAIL reset_release_load: got data=%h vld=%b pls=%b, want 44332211 1111 1111",
                  out_data, out_valid, load_pulse);
      end
   endtask

   task automatic test_hold();
      sel   = 4'b0000;
      ivld  = 4'b1111;
      idata = 32'h000000A5;
      step();
      sel = 4'b0001;
      for (int k = 1; k <= 5; k++) begin
         idata = $urandom;
         step();
         if (k == 1) begin
            vectors++;
            if (load_pulse[0] !== 1'b0) begin
               miscompares++;
               $display("FAIL hold_pulse_clear: got %b want 0", load_pulse[0]);
            end
         end
         if (k == 3 || k == 5) begin
            vectors++;
            if (stale[0] !== 1'b1 || out_data[7:0] !== 8'hA5) begin
               miscompares++;
               $display("FAIL hold_stale_%0d: got stale=%b data=%h want 1 a5", k, stale[0], out_data[7:0]);
            end
         end
      end
   endtask

   task automatic test_enable_freeze();
      logic [31:0] snap;
      sel   = 4'b0000;
      ivld  = 4'b1111;
      idata = 32'h12345678;
      step();
      sel = 4'b0010;
      step();
      step();
      snap = out_data;
      enb  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idata = $urandom;
         sel   = 4'($urandom);
         step();
         vectors++;
         if (stale[1] !== 1'b0 || out_data !== snap || load_pulse !== 4'b0000) begin
            miscompares++;
            $display("FAIL freeze: got stale1=%b data=%h pls=%b want 0 %h 0000",
                     stale[1], out_data, load_pulse, snap);
         end
      end
      enb = 1'b1;
      sel = 4'b0010;
      step();
      vectors++;
      if (stale[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL freeze_resume_stale: got %b want 1", stale[1]);
      end
   endtask

   task automatic test_invalid_load();
      sel   = 4'b0000;
      ivld  = 4'b1111;
      idata = 32'hCAFEBABE;
      step();
      sel = 4'b0100;
      for (int k = 0; k < 3; k++) step();
      vectors++;
      if (stale[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL invalid_pre_stale: got %b want 1", stale[2]);
      end
      sel   = 4'b1011;
      ivld  = 4'b1011;
      idata = 32'h007E0000;
      step();
      vectors++;
      if (out_data[23:16] !== 8'h7E || out_valid[2] !== 1'b0 || stale[2] !== 1'b0 || load_pulse[2] !== 1'b0) begin
         miscompares++;
         $display("FAIL invalid_load: got data=%h vld=%b stl=%b pls=%b want 7e 0 0 0",
                  out_data[23:16], out_valid[2], stale[2], load_pulse[2]);
      end
   endtask

   task automatic test_mixed_reset();
      logic [31:0] snap;
      sel   = 4'b0000;
      ivld  = 4'b1111;
      idata = 32'h99AABBCC;
      step();
      sel = 4'b1111;
      step();
      snap  = out_data;
      sel   = 4'b1110;
      idata = 32'h55667701;
      step();
      vectors++;
      if (out_data[31:8] !== snap[31:8] || out_data[7:0] !== 8'h01 || load_pulse !== 4'b0001) begin
         miscompares++;
         $display("FAIL mixed_channels: got data=%h pls=%b want %h01 0001",
                  out_data, load_pulse, snap[31:8]);
      end
      #3;
      reset_L = 1'b0;
      #1;
      vectors++;
      if ({out_data, out_valid, load_pulse, stale, out_parity} !== 48'h0) begin
         miscompares++;
         $display("FAIL async_reset: got data=%h vld=%b pls=%b stl=%b want all zero",
                  out_data, out_valid, load_pulse, stale);
      end
      model_reset();
      @(posedge clk);
      #1;
      reset_L = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 40; k++) begin
         enb   = ($urandom_range(0, 7) != 0);
         sel   = 4'($urandom);
         ivld  = 4'($urandom);
         idata = $urandom;
         step();
      end
      enb = 1'b1;
   endtask

`ifdef TRANSLATER_PARITY_EN
   task automatic test_parity();
      sel   = 4'b0000;
      ivld  = 4'b1111;
      idata = 32'h00000007;
      step();
      vectors++;
      if (out_parity[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL parity_07: got %b want 1", out_parity[0]);
      end
      idata = 32'h00000003;
      step();
      vectors++;
      if (out_parity[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL parity_03: got %b want 0", out_parity[0]);
      end
      sel   = 4'b0001;
      idata = 32'h00000001;
      step();
      vectors++;
      if (out_parity[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL parity_hold: got %b want 0", out_parity[0]);
      end
   endtask
`endif

   initial begin
      reset_L = 1'b0;
      enb     = 1'b0;
      sel     = 4'b0000;
      ivld    = 4'b0000;
      idata   = 32'h0;
      model_reset();
      #1;
      test_reset();
      test_hold();
      test_enable_freeze();
      test_invalid_load();
      test_mixed_reset();
      test_back_to_back();
`ifdef TRANSLATER_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
